// File: rtl/bsg_link_piso_stage_pkg.sv
// Shared link package: state encoding and parameter helpers for the
// parallel-in/serial-out stage and the matching serial-in/parallel-out stage.
package bsg_link_piso_stage_pkg;

    // EMPTY: no word held. SHIFT: a word is held and its chunks are being emitted.
    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_SHIFT = 1'b1
    } piso_state_e;

    // Width of one chunk when a word is split into els pieces.
    function automatic int chunk_width(input int width, input int els);
        return width / els;
    endfunction

    // A word must split into a whole number of chunks, at least one per word.
    function automatic bit params_legal(input int width, input int els);
        return (els >= 1) && (els <= width) && ((width % els) == 0);
    endfunction

endpackage

// File: rtl/bsg_link_piso_stage_chk.sv
// Simulation-only protocol checks for bsg_link_piso_stage.
// Ports: clk_i/reset_n_i, upstream v_i/yumi_o, downstream v_o/ready_i/data_o,
// and the internal chunk counter cnt_i.
module bsg_link_piso_stage_chk
    import bsg_link_piso_stage_pkg::*;
#(
    parameter int width_p   = 16,
    parameter int els_p     = 4,
    parameter int lg_els_lp = 2,
    parameter int cw_lp     = 4
) (
    input logic                 clk_i,
    input logic                 reset_n_i,
    input logic                 v_i,
    input logic                 yumi_o,
    input logic                 v_o,
    input logic                 ready_i,
    input logic [cw_lp-1:0]     data_o,
    input logic [lg_els_lp-1:0] cnt_i
);

    // Parameter combination must describe a whole number of chunks.
    a_params_legal: assert property (@(posedge clk_i) params_legal(width_p, els_p));

    // The upstream FIFO may only be dequeued while it offers a word.
    a_yumi_needs_v: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        yumi_o |-> v_i);

    // A stalled chunk stays valid and unchanged until it is taken.
    a_stall_stable: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        (v_o && !ready_i) |=> (v_o && $stable(data_o)));

    // The counter wraps by compare and never reaches els_p.
    a_cnt_range: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        int'(cnt_i) < els_p);

endmodule

// File: rtl/bsg_link_piso_stage.sv
// Width-narrowing parallel-in/serial-out stage.
// Takes full-width words from a valid/yumi FIFO interface and emits them as
// els_p chunks, LSB chunk first, on a valid/ready link interface. Holds one
// word; the next word is loaded on the same cycle the last chunk fires, so
// back-to-back words stream without a bubble.
// Ports:
//   clk_i, reset_n_i      clock, asynchronous active-low reset
//   v_i, data_i, yumi_o   upstream word valid, word, consume strobe
//   v_o, data_o           chunk valid, current chunk
//   first_o, last_o       chunk is chunk 0 / chunk els_p-1 of its word
//   ready_i               downstream accepts chunk when v_o & ready_i
module bsg_link_piso_stage
    import bsg_link_piso_stage_pkg::*;
#(
    parameter  int width_p   = 16,
    parameter  int els_p     = 4,
    localparam int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1,
    localparam int cw_lp     = chunk_width(width_p, els_p)
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               yumi_o,
    output logic               v_o,
    output logic [cw_lp-1:0]   data_o,
    output logic               first_o,
    output logic               last_o,
    input  logic               ready_i
);

    piso_state_e            state_r, w_state_n;
    logic [width_p-1:0]     data_r,  w_data_n;
    logic [lg_els_lp-1:0]   cnt_r,   w_cnt_n;

    logic                   w_full;
    logic                   w_last;
    logic                   w_fire;
    logic                   w_last_fire;
    logic [els_p-1:0][cw_lp-1:0] w_chunks;

    assign w_full      = (state_r == ST_SHIFT);
    assign w_last      = (cnt_r == lg_els_lp'(els_p - 1));
    assign w_fire      = w_full & ready_i;
    assign w_last_fire = w_fire & w_last;
    assign w_chunks    = data_r;

    // Outputs come straight from state; only yumi_o looks at ready_i.
    assign v_o     = w_full;
    assign data_o  = w_chunks[cnt_r];
    assign first_o = (cnt_r == lg_els_lp'(0));
    assign last_o  = w_last;
    assign yumi_o  = v_i & (~w_full | w_last_fire);

    // Next-state: load when empty or when the last chunk leaves, else advance on fire.
    always_comb begin
        w_state_n = state_r;
        w_data_n  = data_r;
        w_cnt_n   = cnt_r;
        case (state_r)
            ST_EMPTY: begin
                if (v_i) begin
                    w_data_n  = data_i;
                    w_cnt_n   = lg_els_lp'(0);
                    w_state_n = ST_SHIFT;
                end else begin
                    w_state_n = ST_EMPTY;
                end
            end
            ST_SHIFT: begin
                if (w_last_fire) begin
                    w_cnt_n = lg_els_lp'(0);
                    if (v_i) begin
                        w_data_n  = data_i;
                        w_state_n = ST_SHIFT;
                    end else begin
                        w_state_n = ST_EMPTY;
                    end
                end else if (w_fire) begin
                    w_cnt_n = cnt_r + lg_els_lp'(1);
                end else begin
                    w_cnt_n = cnt_r;
                end
            end
            default: begin
                w_state_n = ST_EMPTY;
                w_cnt_n   = lg_els_lp'(0);
            end
        endcase
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= ST_EMPTY;
            data_r  <= '0;
            cnt_r   <= lg_els_lp'(0);
        end else begin
            state_r <= w_state_n;
            data_r  <= w_data_n;
            cnt_r   <= w_cnt_n;
        end
    end

    bsg_link_piso_stage_chk #(
        .width_p   (width_p),
        .els_p     (els_p),
        .lg_els_lp (lg_els_lp),
        .cw_lp     (cw_lp)
    ) u_chk (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .v_i       (v_i),
        .yumi_o    (yumi_o),
        .v_o       (v_o),
        .ready_i   (ready_i),
        .data_o    (data_o),
        .cnt_i     (cnt_r)
    );

endmodule

// File: tb/tb_bsg_link_piso_stage.sv
// Bench for bsg_link_piso_stage: three configurations (16/4, 8/1, 12/3) are
// driven from per-instance word sources and compared every cycle against a
// queue model that splits each accepted word into its chunks.
module tb_bsg_link_piso_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        v_in [3];
    logic        rdy  [3];
    logic [15:0] din  [3];
    logic        yumi [3];
    logic        vo   [3];
    logic        fst  [3];
    logic        lst  [3];
    logic [15:0] dout [3];

    wire [3:0] d0;
    wire [7:0] d1;
    wire [3:0] d2;

    assign dout[0] = {12'd0, d0};
    assign dout[1] = {8'd0, d1};
    assign dout[2] = {12'd0, d2};

    bsg_link_piso_stage #(.width_p(16), .els_p(4)) u_dut0 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_in[0]), .data_i(din[0]),
        .yumi_o(yumi[0]), .v_o(vo[0]), .data_o(d0), .first_o(fst[0]),
        .last_o(lst[0]), .ready_i(rdy[0]));

    bsg_link_piso_stage #(.width_p(8), .els_p(1)) u_dut1 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_in[1]), .data_i(din[1][7:0]),
        .yumi_o(yumi[1]), .v_o(vo[1]), .data_o(d1), .first_o(fst[1]),
        .last_o(lst[1]), .ready_i(rdy[1]));

    bsg_link_piso_stage #(.width_p(12), .els_p(3)) u_dut2 (
        .clk_i(clk), .reset_n_i(rst_n), .v_i(v_in[2]), .data_i(din[2][11:0]),
        .yumi_o(yumi[2]), .v_o(vo[2]), .data_o(d2), .first_o(fst[2]),
        .last_o(lst[2]), .ready_i(rdy[2]));

    int els_k [3] = '{4, 1, 3};
    int cw_k  [3] = '{4, 8, 4};

    // Model: queue of pending chunks (value and position within its word).
    logic [15:0] mq_d [3][64];
    int          mq_i [3][64];
    int          hd [3];
    int          tl [3];
    logic [15:0] last_word [3];

    // Word sources feeding v_i/data_i.
    logic [15:0] src [3][64];
    int          shd [3];
    int          stl [3];

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s[%0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    function automatic logic [15:0] chunk_of(input int k, input logic [15:0] w, input int c);
        int mask;
        mask = (1 << cw_k[k]) - 1;
        return 16'((int'(w) >> (c * cw_k[k])) & mask);
    endfunction

    function automatic int head_idx(input int k);
        return (hd[k] < tl[k]) ? mq_i[k][hd[k] % 64] : -1;
    endfunction

    task automatic push_src(input int k, input logic [15:0] w);
        src[k][stl[k] % 64] = w;
        stl[k]++;
    endtask

    // One clock cycle: drive sources, check every output, then advance the model.
    task automatic cycle();
        logic        ev [3];
        logic        ey [3];
        logic [15:0] ed;
        logic        ef, el;
        int          mask;
        for (int k = 0; k < 3; k++) begin
            v_in[k] = (shd[k] < stl[k]);
            din[k]  = v_in[k] ? src[k][shd[k] % 64] : 16'h0000;
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            ev[k] = (hd[k] < tl[k]);
            if (ev[k]) begin
                ed = mq_d[k][hd[k] % 64];
                ef = (head_idx(k) == 0);
                el = (head_idx(k) == els_k[k] - 1);
            end else begin
                ed = chunk_of(k, last_word[k], 0);
                ef = 1'b1;
                el = (els_k[k] == 1);
            end
            ey[k] = v_in[k] & (~ev[k] | (rdy[k] & el));
            chk("v_o",     k, {15'd0, vo[k]},   {15'd0, ev[k]});
            chk("data_o",  k, dout[k],          ed);
            chk("first_o", k, {15'd0, fst[k]},  {15'd0, ef});
            chk("last_o",  k, {15'd0, lst[k]},  {15'd0, el});
            chk("yumi_o",  k, {15'd0, yumi[k]}, {15'd0, ey[k]});
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (ev[k] && rdy[k]) hd[k]++;
            if (ey[k]) begin
                mask = (1 << (els_k[k] * cw_k[k])) - 1;
                last_word[k] = 16'(int'(din[k]) & mask);
                for (int c = 0; c < els_k[k]; c++) begin
                    mq_d[k][tl[k] % 64] = chunk_of(k, din[k], c);
                    mq_i[k][tl[k] % 64] = c;
                    tl[k]++;
                end
                shd[k]++;
            end
        end
        @(negedge clk);
    endtask

    // Assert reset between edges and check the outputs clear without a clock.
    task automatic do_reset();
        #2;
        for (int k = 0; k < 3; k++) v_in[k] = 1'b0;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_v_o",     k, {15'd0, vo[k]},   16'd0);
            chk("rst_data_o",  k, dout[k],          16'd0);
            chk("rst_first_o", k, {15'd0, fst[k]},  16'd1);
            chk("rst_last_o",  k, {15'd0, lst[k]},  (els_k[k] == 1) ? 16'd1 : 16'd0);
            chk("rst_yumi_o",  k, {15'd0, yumi[k]}, 16'd0);
            hd[k] = 0;
            tl[k] = 0;
            last_word[k] = 16'h0000;
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        int stalls;
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            v_in[k] = 1'b0; rdy[k] = 1'b1; din[k] = 16'h0000;
            hd[k] = 0; tl[k] = 0; shd[k] = 0; stl[k] = 0; last_word[k] = 16'h0000;
        end
        @(negedge clk);
        do_reset();

        // Single word, ready held high.
        push_src(0, 16'hABCD);
        repeat (7) cycle();

        // Two back-to-back words.
        push_src(0, 16'h1234);
        push_src(0, 16'h5678);
        repeat (11) cycle();

        // Stall three cycles on chunk 2 while the next word waits upstream.
        push_src(0, 16'hABCD);
        push_src(0, 16'h5555);
        stalls = 0;
        for (int i = 0; i < 14; i++) begin
            rdy[0] = !((head_idx(0) == 2) && (stalls < 3));
            if (!rdy[0]) stalls++;
            cycle();
        end
        rdy[0] = 1'b1;
        chk("stall_count", 0, 16'(stalls), 16'd3);

        // Reset in the middle of a word, after chunk C has gone.
        push_src(0, 16'hABCD);
        guard = 0;
        while ((head_idx(0) != 2) && (guard < 10)) begin
            cycle();
            guard++;
        end
        if (guard >= 10) chk("rst_reach_timeout", 0, 16'(guard), 16'd0);
        do_reset();
        push_src(0, 16'h9876);
        repeat (6) cycle();

        // Three chunks per word, and a one-chunk pipeline with random ready.
        push_src(2, 16'h0FED);
        for (int i = 1; i <= 5; i++) push_src(1, 16'(i));
        repeat (5) cycle();
        for (int i = 0; i < 12; i++) begin
            rdy[1] = 1'($urandom_range(0, 1));
            cycle();
        end
        rdy[1] = 1'b1;
        repeat (6) cycle();

        // Random traffic on all three instances.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < 3; k++) begin
                if ((stl[k] - shd[k] < 4) && ($urandom_range(0, 1) == 1))
                    push_src(k, 16'($urandom()));
                rdy[k] = ($urandom_range(0, 3) != 0);
            end
            cycle();
        end
        for (int k = 0; k < 3; k++) rdy[k] = 1'b1;
        repeat (40) cycle();

        for (int k = 0; k < 3; k++)
            chk("drained", k, 16'(tl[k] - hd[k]), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
